// File: rtl/kf_pkg.sv
// kf_pkg: shared Kalman datapath widths, typedefs and the zero-register build option
// Build option: DB_ZERO_REG_EN makes data_bank entry 0 a hardwired constant zero.
package kf_pkg;
  localparam int W = 24;
  localparam int ADDRW = 5;
  localparam int DEPTH = 1 << ADDRW;
  typedef logic [W-1:0] word_t;
  typedef logic [ADDRW-1:0] addr_t;
`ifdef DB_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
endpackage

// File: rtl/data_bank_core.sv
// data_bank_core: storage array, init bitmap, write logic and distinct-write counter
// Ports: clk, rst; wr_en/wr_addr/wr_data write port; rd_addr_a/rd_addr_b give
// combinational rd_data_a/b and init_a/b; init_cnt counts distinct entries written.
// Honours DB_ZERO_REG_EN through kf_pkg::ZERO_REG (entry 0 fixed at zero, pre-initialised).
module data_bank_core
  import kf_pkg::*;
#(
  parameter int W = kf_pkg::W,
  parameter int ADDRW = kf_pkg::ADDRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [ADDRW-1:0] rd_addr_a,
  input  logic [ADDRW-1:0] rd_addr_b,
  output logic [W-1:0]     rd_data_a,
  output logic [W-1:0]     rd_data_b,
  output logic             init_a,
  output logic             init_b,
  output logic [ADDRW:0]   init_cnt
);
  localparam int N = 1 << ADDRW;
  localparam logic [N-1:0] INIT_RST = N'(ZERO_REG);
  localparam logic [ADDRW:0] CNT_RST = (ADDRW+1)'(ZERO_REG);
  localparam logic [ADDRW:0] CNT_MAX = (ADDRW+1)'(N);
  logic [W-1:0] mem [N];
  logic [N-1:0] init;
  logic wr_ok;
  // entry 0 is never written in the zero-register build, so it stays 0 and init
  assign wr_ok = wr_en && !(ZERO_REG && wr_addr == '0);
  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign init_a = init[rd_addr_a];
  assign init_b = init[rd_addr_b];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      init <= INIT_RST;
      init_cnt <= CNT_RST;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
      init[wr_addr] <= 1'b1;
      if (!init[wr_addr] && init_cnt != CNT_MAX) init_cnt <= init_cnt + (ADDRW+1)'(1);
    end
  end
endmodule

// File: rtl/data_bank.sv
// data_bank: dual-read operand bank with write-first bypass and uninitialised-read flag
// Ports: clk, rst; db_data/db_dira/db_write write (db_dira also read A); db_dirb read B;
// rd_en reads both ports; ERR_CLR clears UNINIT_ERR; OP_A/OP_B/OP_VALID registered
// operands; UNINIT_ERR sticky flag; INIT_CNT distinct entries written.
// Build option: DB_ZERO_REG_EN (via kf_pkg::ZERO_REG) hardwires entry 0 to zero.
module data_bank
  import kf_pkg::*;
#(
  parameter int W = kf_pkg::W,
  parameter int ADDRW = kf_pkg::ADDRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     db_data,
  input  logic [ADDRW-1:0] db_dira,
  input  logic [ADDRW-1:0] db_dirb,
  input  logic             db_write,
  input  logic             rd_en,
  input  logic             ERR_CLR,
  output logic [W-1:0]     OP_A,
  output logic [W-1:0]     OP_B,
  output logic             OP_VALID,
  output logic             UNINIT_ERR,
  output logic [ADDRW:0]   INIT_CNT
);
  logic [W-1:0] mem_a, mem_b;
  logic init_a, init_b, byp_a, byp_b, bad;
  data_bank_core #(.W(W), .ADDRW(ADDRW)) u_core (
    .clk(clk),
    .rst(rst),
    .wr_en(db_write),
    .wr_addr(db_dira),
    .wr_data(db_data),
    .rd_addr_a(db_dira),
    .rd_addr_b(db_dirb),
    .rd_data_a(mem_a),
    .rd_data_b(mem_b),
    .init_a(init_a),
    .init_b(init_b),
    .init_cnt(INIT_CNT)
  );
  // port A always reads the write address, so it bypasses on every write
  assign byp_a = db_write && !(ZERO_REG && db_dira == '0);
  assign byp_b = byp_a && db_dirb == db_dira;
  assign bad = (!init_a && !byp_a) || (!init_b && !byp_b);
  always_ff @(posedge clk) begin
    if (rst) begin
      OP_A <= '0;
      OP_B <= '0;
      OP_VALID <= 1'b0;
      UNINIT_ERR <= 1'b0;
    end else begin
      OP_VALID <= rd_en;
      if (rd_en) begin
        OP_A <= byp_a ? db_data : mem_a;
        OP_B <= byp_b ? db_data : mem_b;
      end
      UNINIT_ERR <= (rd_en && bad) || (UNINIT_ERR && !ERR_CLR);
    end
  end
endmodule

// File: doc/data_bank.md
# data_bank

Operand storage for the Kalman datapath: a 2^ADDRW × W register bank that sits directly downstream of `router_a`. It consumes the router's `db_data` / `db_dira` / `db_dirb` / `db_write` outputs:

- writes `db_data` at address `db_dira`;
- returns two registered operands (A at `db_dira`, B at `db_dirb`) to the arithmetic unit one cycle later;
- tracks which entries have been written since reset, and flags reads of unwritten entries.

## Interface
Parameters:
- `W`, 24, word width (fixed-point operand).
- `ADDRW`, 5, address width; depth = 2^ADDRW = 32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `db_data`  in  W  write data from the router.
- `db_dira`  in  ADDRW  port A address; used for both the write and the A read.
- `db_dirb`  in  ADDRW  port B address; read only.
- `db_write`  in  1  write enable.
- `rd_en`  in  1  read request for both ports.
- `ERR_CLR`  in  1  clears the sticky error.
- `OP_A`  out  W  registered operand A.
- `OP_B`  out  W  registered operand B.
- `OP_VALID`  out  1  OP_A/OP_B were updated by the previous cycle's `rd_en`.
- `UNINIT_ERR`  out  1  sticky flag: an unwritten entry was read.
- `INIT_CNT`  out  ADDRW+1  number of distinct entries written since reset.

## Operation
- Storage: `mem[0..2^ADDRW-1]`, each W bits, plus an init bitmap `init[0..2^ADDRW-1]`.
- Write: when `db_write` is high, `mem[db_dira] <= db_data` and `init[db_dira] <= 1`.
- Write counter: `INIT_CNT` increments by 1 only when a write hits an entry whose init bit is 0. Rewrites do not change it. The counter saturates at 2^ADDRW; it cannot exceed that value.
- Read: when `rd_en` is high:
  - `OP_A <= mem[db_dira]` and `OP_B <= mem[db_dirb]`.
  - Write-first bypass: if `db_write` is high and a read address equals `db_dira`, that port returns `db_data`, not the stale entry.
- Hold: when `rd_en` is low, `OP_A` and `OP_B` hold their values.
- Uninitialised-read detection, per read port: the port is uninitialised when its init bit is 0 and it is not being bypassed that cycle. If either port is uninitialised on an `rd_en` cycle, `UNINIT_ERR <= 1`.
- Error clear: `ERR_CLR` clears `UNINIT_ERR`. If a new error occurs in the same cycle as `ERR_CLR`, set wins.
- Widths: data is passed unmodified; no arithmetic on W-bit data.

## Timing
- Write latency: 1 cycle. Data written at edge n is readable from memory at edge n+1; the bypass makes it visible in the same-cycle read.
- Read latency: 1 cycle. `rd_en` sampled at edge n gives `OP_A`, `OP_B` and `OP_VALID` = 1 after edge n.
- `OP_VALID` is a one-cycle-delayed copy of `rd_en`.
- `UNINIT_ERR` is updated at the same edge as the operands.
- Reset, when `rst` = 1 at an edge:
  - all `mem` entries and init bits go to 0;
  - `OP_A` = 0, `OP_B` = 0, `OP_VALID` = 0, `UNINIT_ERR` = 0;
  - `INIT_CNT` = 0, or 1 with `DB_ZERO_REG_EN`.
- Reset has priority over a simultaneous write, read and `ERR_CLR`; none of them take effect.
- A read of the same address on both ports is legal, and both ports return the same value.
- No back-pressure: every cycle accepts one write plus one dual read.

## Configuration
- `DB_ZERO_REG_EN` defined: entry 0 is a hardwired constant zero.
  - Writes to address 0 are discarded and do not touch `INIT_CNT`.
  - Reads of address 0 return 0 and never raise `UNINIT_ERR`.
  - Bypass is suppressed for address 0.
  - `init[0]` is 1 from reset, so `INIT_CNT` resets to 1.
- Undefined: entry 0 is an ordinary entry.

## Structure
- Shared package `kf_pkg` holds the `W` = 24 and `ADDRW` = 5 defaults, the `word_t` and `addr_t` typedefs, and the `DEPTH` constant. These are the same definitions `router_a` uses.
- One sub-module, `data_bank_core`, holds the storage array, the init bitmap, the write logic and the counter. It exposes combinational read data and init bits for both addresses.
- The top level adds the bypass, the output registers and the error flag.

## Test plan
1. Reset, then `rd_en` with `db_dira`=0x03, `db_dirb`=0x1C → next cycle: `OP_A`=0, `OP_B`=0, `OP_VALID`=1, `UNINIT_ERR`=1, `INIT_CNT`=0.
2. Write 0xC0FFEE to 0x03; next cycle `rd_en` with `db_dira`=0x03 → `OP_A`=0xC0FFEE, `INIT_CNT`=1. Rewrite 0x03 with 0x000001 → `INIT_CNT` stays 1.
3. Same cycle: `db_write` 0x123456 at `db_dira`=0x12, `db_dirb`=0x12, `rd_en`=1, with `UNINIT_ERR` cleared beforehand → `OP_A`=`OP_B`=0x123456, `UNINIT_ERR` stays 0.
4. `ERR_CLR`=1 in the same cycle as an `rd_en` of unwritten 0x1F → `UNINIT_ERR`=1. `ERR_CLR` alone on the next cycle → `UNINIT_ERR`=0.
5. `rst`=1 in the same cycle as a write of 0xABCDEF to 0x05, then read 0x05 → `OP_A`=0, `UNINIT_ERR`=1, `INIT_CNT`=0.
6. With `DB_ZERO_REG_EN`: write 0xFFFFFF to 0x00, then read 0x00 → `OP_A`=0, `UNINIT_ERR`=0, `INIT_CNT`=1. Write all 32 addresses → `INIT_CNT`=32.
